// File: rtl/multiplexer_rr.sv
// multiplexer_rr: four-channel round-robin merge into one registered, source-tagged output word
module multiplexer_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [WIDTH-1:0] dataC,
  input  logic [WIDTH-1:0] dataD,
  input  logic             validA,
  input  logic             validB,
  input  logic             validC,
  input  logic             validD,
  output logic             readyA,
  output logic             readyB,
  output logic             readyC,
  output logic             readyD,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam logic [0:0] IDLE = 1'b0, HOLD = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, gnt;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_w [4];
  logic [3:0]       valid, ready;
  logic             any, take;
  assign valid  = {validD, validC, validB, validA};
  assign data_w = '{dataA, dataB, dataC, dataD};
  // scan from lowest priority to highest so the first requester after ptr wins
  always_comb begin
    gnt = ptr_q;
    any = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (valid[ptr_q + 2'(i)]) begin
        gnt = ptr_q + 2'(i);
        any = 1'b1;
      end
  end
  assign take  = state_q == IDLE && any;
  assign ready = take ? 4'b0001 << gnt : 4'b0000;
  assign {readyD, readyC, readyB, readyA} = ready;
  always_comb begin
    state_d = take ? HOLD : (state_q == HOLD && out_ready) ? IDLE : state_q;
    ptr_d   = take ? gnt + 2'd1 : ptr_q;
    data_d  = take ? data_w[gnt] : data_q;
    sel_d   = take ? gnt : sel_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end
  assign out_valid = state_q == HOLD;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
endmodule

// File: tb/tb_multiplexer_rr.sv
// tb_multiplexer_rr: directed scoreboard bench for the round-robin multiplexer
module tb_multiplexer_rr;
  logic       clk = 1'b0, reset = 1'b1, out_ready = 1'b0;
  logic [7:0] dataA = '0, dataB = '0, dataC = '0, dataD = '0;
  logic       validA = 1'b0, validB = 1'b0, validC = 1'b0, validD = 1'b0;
  logic       readyA, readyB, readyC, readyD, out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [9:0] sb [$];
  int n_cmp = 0, n_err = 0;

  multiplexer_rr #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataD(dataD),
    .validA(validA), .validB(validB), .validC(validC), .validD(validD),
    .readyA(readyA), .readyB(readyB), .readyC(readyC), .readyD(readyD),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] rdy();
    return {readyD, readyC, readyB, readyA};
  endfunction

  task automatic push(input logic [7:0] d, input logic [1:0] s);
    sb.push_back({s, d});
  endtask

  task automatic accept(input string tag);
    logic [9:0] e;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) step();
    chk({tag, "_valid"}, out_valid, 1);
    e = sb.size() > 0 ? sb.pop_front() : 10'h3ff;
    chk({tag, "_data"}, out_data, e[7:0]);
    chk({tag, "_sel"}, out_sel, e[9:8]);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
  endtask

  initial begin
    logic [9:0] e;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_ready", rdy(), 0);
    reset = 1'b0;
    // single word from B, held for 5 cycles
    validB = 1'b1; dataB = 8'h5A;
    #1 chk("b_ready", rdy(), 4'b0010);
    push(8'h5A, 2'd1);
    step();
    validB = 1'b0;
    chk("b_ready_off", rdy(), 0);
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_valid", out_valid, 1);
      chk("b_hold_data", out_data, 8'h5A);
      step();
    end
    accept("b");
    // all channels continuously valid, sink always ready
    reset = 1'b1; step(); reset = 1'b0;
    dataA = 8'h11; dataB = 8'h22; dataC = 8'h33; dataD = 8'h44;
    {validD, validC, validB, validA} = 4'b1111;
    #1 chk("rr_one_ready", rdy(), 4'b0001);
    push(8'h11, 0); push(8'h22, 1); push(8'h33, 2); push(8'h44, 3); push(8'h11, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rr_valid", out_valid, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) begin
        e = sb.size() > 0 ? sb.pop_front() : 10'h3ff;
        chk("rr_data", out_data, e[7:0]);
        chk("rr_sel", out_sel, e[9:8]);
      end
    end
    {validD, validC, validB, validA} = 4'b0000;
    out_ready = 1'b0;
    // serve C to bring ptr to 11, then A and D: D first, then A
    validC = 1'b1;
    #1 chk("c_ready", rdy(), 4'b0100);
    push(8'h33, 2);
    step(); validC = 1'b0;
    accept("c");
    validA = 1'b1; validD = 1'b1;
    #1 chk("wrap_d_ready", rdy(), 4'b1000);
    push(8'h44, 3);
    step(); validD = 1'b0;
    accept("wrap_d");
    chk("wrap_a_ready", rdy(), 4'b0001);
    push(8'h11, 0);
    step(); validA = 1'b0;
    accept("wrap_a");
    // stall with C waiting
    validA = 1'b1;
    push(8'h11, 0);
    step(); validA = 1'b0;
    validC = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("stall_ready", rdy(), 0);
      chk("stall_data", out_data, 8'h11);
      step();
    end
    accept("stall_a");
    chk("stall_c_ready", rdy(), 4'b0100);
    push(8'h33, 2);
    step(); validC = 1'b0;
    accept("stall_c");
    // asynchronous reset in the middle of HOLD drops the held word
    validB = 1'b1;
    step(); validB = 1'b0;
    chk("arst_held", out_valid, 1);
    #2 reset = 1'b1;
    #1 chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_sel", out_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    validD = 1'b1;
    #1 chk("arst_d_ready", rdy(), 4'b1000);
    push(8'h44, 3);
    step(); validD = 1'b0;
    accept("arst_d");
    // B pulses only while the block is busy and must never be taken
    validA = 1'b1;
    push(8'h11, 0);
    step(); validA = 1'b0;
    validB = 1'b1;
    #1 chk("pulse_ready", rdy(), 0);
    step(); validB = 1'b0;
    accept("pulse_a");
    for (int i = 0; i < 3; i++) begin
      chk("pulse_idle_valid", out_valid, 0);
      chk("pulse_idle_ready", rdy(), 0);
      step();
    end
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
